layer_sequencer: RTL and testbench



---
 rtl/layer_sequencer_if.sv | 49 ++++
 rtl/layer_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : layer_sequencer_if
// Purpose  : Bundles the host-side control/status signals and the per-engine
//            handshake of the layer sequencer into a single interface.
//            slave  - view used by the sequencer itself
//            master - view used by the host / engine side (or a testbench)
// Signals  : start, abort, num_layers, cfg_we, cfg_idx, cfg_type  (host -> seq)
//            busy, done, error                                    (seq -> host)
//            eng_done                                             (eng -> seq)
//            eng_en, eng_clr_n, src_base, des_base, layer_idx     (seq -> eng)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ADDR_SZ
`define ADDR_SZ 16
`endif

interface layer_sequencer_if #(
  parameter int LAYER_W = 4
);
  logic                start;
  logic                abort;
  logic [LAYER_W:0]    num_layers;
  logic                cfg_we;
  logic [LAYER_W-1:0]  cfg_idx;
  logic [1:0]          cfg_type;
  logic [3:0]          eng_done;
  logic [3:0]          eng_en;
  logic [3:0]          eng_clr_n;
  logic [`ADDR_SZ-1:0] src_base;
  logic [`ADDR_SZ-1:0] des_base;
  logic [LAYER_W-1:0]  layer_idx;
  logic                busy;
  logic                done;
  logic                error;

  modport slave (
    input  start, abort, num_layers, cfg_we, cfg_idx, cfg_type, eng_done,
    output eng_en, eng_clr_n, src_base, des_base, layer_idx, busy, done, error
  );

  modport master (
    output start, abort, num_layers, cfg_we, cfg_idx, cfg_type, eng_done,
    input  eng_en, eng_clr_n, src_base, des_base, layer_idx, busy, done, error
  );
endinterface

`default_nettype wire

// File: rtl/layer_sequencer.sv
//------------------------------------------------------------------------------
// Module   : layer_sequencer
// Purpose  : Top-level layer scheduler for the tiny-YOLO accelerator. Walks a
//            programmable layer table; for each layer it rearms the selected
//            engine (conv/maxpool/upsample/route), enables it until that
//            engine reports done, then swaps the ping-pong feature buffers.
// Ports    : clk      - clock
//            reset_n  - asynchronous active-low reset
//            bus      - layer_sequencer_if.slave (host control, engine
//                       enables/rearm/done, buffer bases, status)
// Options  : LAYER_TIMEOUT_EN - adds a per-layer watchdog (TIMEOUT cycles in
//            RUN) and an ERROR state; without it error is tied low and RUN
//            waits indefinitely for the engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ADDR_SZ
`define ADDR_SZ 16
`endif

module layer_sequencer #(
  parameter int                  NUM_LAYERS = 16,
  parameter int                  LAYER_W    = 4,
  parameter logic [`ADDR_SZ-1:0] BUF_A_BASE = '0,
  parameter logic [`ADDR_SZ-1:0] BUF_B_BASE = `ADDR_SZ'(32768)
`ifdef LAYER_TIMEOUT_EN
  ,
  parameter logic [15:0]         TIMEOUT    = 16'hFFFF
`endif
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  layer_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_RUN    = 3'd2,
    S_SWAP   = 3'd3,
    S_FINISH = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t             r_state;
  logic [1:0]         r_table [NUM_LAYERS];
  logic [LAYER_W:0]   r_num;
  logic [LAYER_W-1:0] r_layer_idx;
  logic               r_buf_sel;
  logic [1:0]         r_type;       // engine type of the layer in flight
  logic [3:0]         r_eng_en;
  logic [3:0]         r_eng_clr_n;
  logic               r_busy;
  logic               r_done;

  logic [LAYER_W-1:0] w_idx_next;
  logic               w_last;
  logic [1:0]         w_type_first;
  logic [1:0]         w_type_next;

  function automatic logic [3:0] f_onehot(input logic [1:0] t);
    f_onehot = 4'b0001 << t;
  endfunction

  assign w_idx_next   = r_layer_idx + LAYER_W'(1);
  assign w_last       = ({1'b0, r_layer_idx} == (r_num - (LAYER_W+1)'(1)));
  assign w_type_first = r_table[0];
  assign w_type_next  = r_table[w_idx_next];

  // Layer table: host writes only land while idle so the running program
  // cannot be changed underneath the sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_table[i] <= 2'd0;
      end
    end else if (bus.cfg_we && (r_state == S_IDLE)) begin
      r_table[bus.cfg_idx] <= bus.cfg_type;
    end
  end

`ifdef LAYER_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_error;
`endif

  // Sequencer FSM. All engine-facing and status outputs are registered and
  // take their value together with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_layer_idx <= '0;
      r_buf_sel   <= 1'b0;
      r_type      <= 2'd0;
      r_eng_en    <= 4'h0;
      r_eng_clr_n <= 4'hF;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef LAYER_TIMEOUT_EN
      r_cnt       <= 16'd0;
      r_error     <= 1'b0;
`endif
    end else if (bus.abort) begin
      // Abort overrides every transition; rearm every engine for one cycle.
      // layer_idx and buf_sel are kept so the aborted position is visible.
      r_state     <= S_IDLE;
      r_eng_en    <= 4'h0;
      r_eng_clr_n <= 4'h0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef LAYER_TIMEOUT_EN
      r_error     <= 1'b0;
`endif
    end else begin
      r_eng_clr_n <= 4'hF;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_num       <= bus.num_layers;
            r_layer_idx <= '0;
            r_buf_sel   <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.num_layers == '0) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_ARM;
              r_type      <= w_type_first;
              r_eng_clr_n <= ~f_onehot(w_type_first);
            end
          end
        end

        S_ARM: begin
          r_state  <= S_RUN;
          r_eng_en <= f_onehot(r_type);
`ifdef LAYER_TIMEOUT_EN
          r_cnt    <= 16'd0;
`endif
        end

        S_RUN: begin
          // Only the done bit of the engine in flight matters.
          if (bus.eng_done[r_type]) begin
            r_state   <= S_SWAP;
            r_eng_en  <= 4'h0;
            r_buf_sel <= ~r_buf_sel;
          end
`ifdef LAYER_TIMEOUT_EN
          else if ((r_cnt + 16'd1) == TIMEOUT) begin
            r_state  <= S_ERROR;
            r_eng_en <= 4'h0;
            r_error  <= 1'b1;
            r_cnt    <= r_cnt + 16'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
`endif
        end

        S_SWAP: begin
          if (w_last) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end else begin
            r_state     <= S_ARM;
            r_layer_idx <= w_idx_next;
            r_type      <= w_type_next;
            r_eng_clr_n <= ~f_onehot(w_type_next);
          end
        end

        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        // Watchdog trip: parked until abort or reset.
        S_ERROR: begin
          r_state <= S_ERROR;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.eng_en    = r_eng_en;
  assign bus.eng_clr_n = r_eng_clr_n;
  assign bus.src_base  = r_buf_sel ? BUF_B_BASE : BUF_A_BASE;
  assign bus.des_base  = r_buf_sel ? BUF_A_BASE : BUF_B_BASE;
  assign bus.layer_idx = r_layer_idx;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
`ifdef LAYER_TIMEOUT_EN
  assign bus.error     = r_error;
`else
  assign bus.error     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_layer_sequencer
// Purpose  : Self-checking directed testbench for layer_sequencer. An engine
//            model raises the level done of the enabled engine a fixed number
//            of cycles into RUN and logs per-layer enables, buffer bases and
//            rearm pulses; each test task compares the logs against
//            hand-computed values.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_layer_sequencer;

  localparam logic [15:0] c_buf_a = 16'd0;
  localparam logic [15:0] c_buf_b = 16'd32768;

  logic clk;
  logic reset_n;

  int checks   = 0;
  int failures = 0;

  layer_sequencer_if #(.LAYER_W(4)) bus ();

  layer_sequencer #(
    .NUM_LAYERS (16),
    .LAYER_W    (4),
    .BUF_A_BASE (c_buf_a),
    .BUF_B_BASE (c_buf_b)
`ifdef LAYER_TIMEOUT_EN
    ,
    .TIMEOUT    (16'd20)
`endif
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Logs filled by the engine model
  int          n_arm, n_done, k, done_cyc, first_en_cyc, any_en;
  logic [3:0]  clr_log [16];
  logic [3:0]  en_log  [16];
  logic [15:0] src_log [16];
  logic [15:0] des_log [16];
  int          run_len_log [16];
  logic [3:0]  ab_en, ab_clr, ab_clr2, ab_idx;
  logic        ab_busy, ab_done;
  logic [15:0] ab_src;

  task automatic write_cfg(input logic [3:0] idx, input logic [1:0] typ);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = idx;
    bus.cfg_type = typ;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  // Caller raises start at a negedge, then calls this. Samples every negedge.
  task automatic service(input int delay, input int budget, input int abort_layer,
                         input int restart_cyc, input bit busy_write,
                         input logic [3:0] noise);
    int cyc, cnt, tail, ab_state;
    n_arm = 0; n_done = 0; k = 0; done_cyc = -1; first_en_cyc = -1; any_en = 0;
    cyc = 0; cnt = 0; tail = -1; ab_state = 0;
    for (int i = 0; i < 16; i++) begin
      clr_log[i] = '0; en_log[i] = '0; src_log[i] = '0; des_log[i] = '0;
      run_len_log[i] = 0;
    end
    while (cyc < budget && tail != 0) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == restart_cyc);
      if (cyc == 1 && busy_write) begin
        bus.cfg_we = 1'b1; bus.cfg_idx = 4'd0; bus.cfg_type = 2'd3;
      end
      if (bus.eng_clr_n != 4'hF && bus.eng_clr_n != 4'h0) begin
        if (n_arm < 16) clr_log[n_arm] = bus.eng_clr_n;
        n_arm++;
      end
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
        bus.cfg_we = 1'b0;
        if (tail < 0) tail = 3;
      end
      if (bus.eng_en != 4'h0) begin
        any_en = 1;
        if (first_en_cyc < 0) first_en_cyc = cyc;
        if (cnt == 0 && k < 16) begin
          en_log[k] = bus.eng_en; src_log[k] = bus.src_base; des_log[k] = bus.des_base;
        end
        cnt++;
      end else if (cnt != 0) begin
        if (k < 16) run_len_log[k] = cnt;
        k++;
        cnt = 0;
      end
      bus.eng_done = ((bus.eng_en != 4'h0 && cnt >= delay) ? bus.eng_en : 4'h0) |
                     ((bus.eng_en == 4'b0100) ? noise : 4'h0);
      case (ab_state)
        0: if (k == abort_layer && cnt == 2) begin
             bus.abort = 1'b1; ab_state = 1;
           end
        1: begin
             ab_en = bus.eng_en; ab_clr = bus.eng_clr_n; ab_busy = bus.busy;
             ab_done = bus.done; ab_idx = bus.layer_idx; ab_src = bus.src_base;
             bus.abort = 1'b0; ab_state = 2;
           end
        2: begin
             ab_clr2 = bus.eng_clr_n; ab_state = 3; tail = 10;
           end
        default: ;
      endcase
      if (tail > 0) tail--;
    end
    bus.start = 1'b0; bus.eng_done = 4'h0; bus.cfg_we = 1'b0; bus.abort = 1'b0;
  endtask

  task automatic kick(input logic [4:0] n);
    @(negedge clk);
    bus.num_layers = n;
    bus.start      = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.eng_en !== 4'h0) begin failures++; $display("FAIL reset_eng_en got=%h exp=0", bus.eng_en); end
    checks++; if (bus.eng_clr_n !== 4'hF) begin failures++; $display("FAIL reset_clr_n got=%h exp=f", bus.eng_clr_n); end
    checks++; if (bus.layer_idx !== 4'd0) begin failures++; $display("FAIL reset_layer_idx got=%0d exp=0", bus.layer_idx); end
    checks++; if (bus.src_base !== c_buf_a || bus.des_base !== c_buf_b) begin failures++; $display("FAIL reset_bases got=%h/%h exp=%h/%h", bus.src_base, bus.des_base, c_buf_a, c_buf_b); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin failures++; $display("FAIL reset_status got busy=%b done=%b err=%b exp=000", bus.busy, bus.done, bus.error); end
    reset_n = 1'b1;
    // Table resets to type 0: a one-layer run must enable the conv engine.
    kick(5'd1);
    service(2, 40, -1, 0, 1'b0, 4'h0);
    checks++; if (en_log[0] !== 4'b0001) begin failures++; $display("FAIL reset_table_type got=%b exp=0001", en_log[0]); end
  endtask

  task automatic test_single_layer;
    write_cfg(4'd0, 2'd2);
    kick(5'd1);
    service(10, 60, -1, 0, 1'b0, 4'h0);
    checks++; if (n_arm !== 1 || clr_log[0] !== 4'b1011) begin failures++; $display("FAIL single_arm got n=%0d clr=%b exp n=1 clr=1011", n_arm, clr_log[0]); end
    checks++; if (first_en_cyc !== 2) begin failures++; $display("FAIL single_en_latency got=%0d exp=2", first_en_cyc); end
    checks++; if (en_log[0] !== 4'b0100 || run_len_log[0] !== 10) begin failures++; $display("FAIL single_run got en=%b len=%0d exp en=0100 len=10", en_log[0], run_len_log[0]); end
    checks++; if (src_log[0] !== c_buf_a || des_log[0] !== c_buf_b) begin failures++; $display("FAIL single_bases got=%h/%h exp=%h/%h", src_log[0], des_log[0], c_buf_a, c_buf_b); end
    checks++; if (n_done !== 1 || done_cyc !== 13) begin failures++; $display("FAIL single_done got n=%0d cyc=%0d exp n=1 cyc=13", n_done, done_cyc); end
    checks++; if (bus.src_base !== c_buf_b || bus.des_base !== c_buf_a || bus.busy !== 1'b0) begin failures++; $display("FAIL single_final got src=%h des=%h busy=%b exp src=%h des=%h busy=0", bus.src_base, bus.des_base, bus.busy, c_buf_b, c_buf_a); end
  endtask

  task automatic test_four_layers;
    logic [3:0]  exp_en  [4];
    logic [3:0]  exp_clr [4];
    logic [15:0] exp_src [4];
    exp_en  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_clr = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_src = '{c_buf_a, c_buf_b, c_buf_a, c_buf_b};
    for (int i = 0; i < 4; i++) write_cfg(4'(i), 2'(i));
    kick(5'd4);
    service(3, 100, -1, 0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (en_log[i] !== exp_en[i] || src_log[i] !== exp_src[i] || clr_log[i] !== exp_clr[i]) begin failures++; $display("FAIL four_layer%0d got en=%b src=%h clr=%b exp en=%b src=%h clr=%b", i, en_log[i], src_log[i], clr_log[i], exp_en[i], exp_src[i], exp_clr[i]); end
    end
    checks++; if (n_arm !== 4 || k !== 4) begin failures++; $display("FAIL four_counts got arm=%0d layers=%0d exp 4/4", n_arm, k); end
    checks++; if (n_done !== 1 || done_cyc !== 21) begin failures++; $display("FAIL four_done got n=%0d cyc=%0d exp n=1 cyc=21", n_done, done_cyc); end
    checks++; if (bus.layer_idx !== 4'd3 || bus.src_base !== c_buf_a) begin failures++; $display("FAIL four_final got idx=%0d src=%h exp idx=3 src=%h", bus.layer_idx, bus.src_base, c_buf_a); end
  endtask

  task automatic test_zero_layers;
    kick(5'd0);
    service(3, 20, -1, 0, 1'b0, 4'h0);
    checks++; if (n_done !== 1 || done_cyc !== 1) begin failures++; $display("FAIL zero_done got n=%0d cyc=%0d exp n=1 cyc=1", n_done, done_cyc); end
    checks++; if (any_en !== 0 || n_arm !== 0) begin failures++; $display("FAIL zero_no_engine got en_seen=%0d arm=%0d exp 0/0", any_en, n_arm); end
  endtask

  task automatic test_abort;
    for (int i = 0; i < 3; i++) write_cfg(4'(i), 2'(i));
    kick(5'd3);
    service(3, 80, 1, 0, 1'b0, 4'h0);
    checks++; if (ab_en !== 4'h0 || ab_clr !== 4'h0 || ab_busy !== 1'b0 || ab_done !== 1'b0) begin failures++; $display("FAIL abort_outputs got en=%h clr=%h busy=%b done=%b exp 0/0/0/0", ab_en, ab_clr, ab_busy, ab_done); end
    checks++; if (ab_idx !== 4'd1 || ab_src !== c_buf_b) begin failures++; $display("FAIL abort_held got idx=%0d src=%h exp idx=1 src=%h", ab_idx, ab_src, c_buf_b); end
    checks++; if (ab_clr2 !== 4'hF || n_done !== 0) begin failures++; $display("FAIL abort_after got clr=%h done_n=%0d exp clr=f done_n=0", ab_clr2, n_done); end
    kick(5'd3);
    service(3, 80, -1, 0, 1'b0, 4'h0);
    checks++; if (en_log[0] !== 4'b0001 || src_log[0] !== c_buf_a || en_log[2] !== 4'b0100 || src_log[2] !== c_buf_a) begin failures++; $display("FAIL abort_rerun got en0=%b src0=%h en2=%b src2=%h exp 0001/%h/0100/%h", en_log[0], src_log[0], en_log[2], src_log[2], c_buf_a, c_buf_a); end
    checks++; if (n_done !== 1 || done_cyc !== 16) begin failures++; $display("FAIL abort_rerun_done got n=%0d cyc=%0d exp n=1 cyc=16", n_done, done_cyc); end
  endtask

  task automatic test_busy_write_and_noise;
    write_cfg(4'd0, 2'd2);
    kick(5'd1);
    service(6, 60, -1, 0, 1'b1, 4'b0010);
    checks++; if (run_len_log[0] !== 6 || n_done !== 1) begin failures++; $display("FAIL noise_ignored got len=%0d done_n=%0d exp len=6 done_n=1", run_len_log[0], n_done); end
    kick(5'd1);
    service(2, 40, -1, 0, 1'b0, 4'h0);
    checks++; if (en_log[0] !== 4'b0100) begin failures++; $display("FAIL busy_write_ignored got=%b exp=0100", en_log[0]); end
  endtask

  task automatic test_start_rules;
    write_cfg(4'd0, 2'd0);
    write_cfg(4'd1, 2'd1);
    kick(5'd2);
    service(3, 60, -1, 3, 1'b0, 4'h0);
    checks++; if (n_done !== 1 || done_cyc !== 11 || n_arm !== 2) begin failures++; $display("FAIL restart_ignored got n=%0d cyc=%0d arm=%0d exp 1/11/2", n_done, done_cyc, n_arm); end
    // start and abort together in IDLE: stays idle
    @(negedge clk);
    bus.num_layers = 5'd2; bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.eng_clr_n !== 4'h0) begin failures++; $display("FAIL start_abort_busy got busy=%b clr=%h exp busy=0 clr=0", bus.busy, bus.eng_clr_n); end
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.eng_en !== 4'h0 || bus.eng_clr_n !== 4'hF) begin failures++; $display("FAIL start_abort_idle got busy=%b en=%h clr=%h exp 0/0/f", bus.busy, bus.eng_en, bus.eng_clr_n); end
  endtask

`ifdef LAYER_TIMEOUT_EN
  task automatic test_timeout;
    write_cfg(4'd0, 2'd1);
    kick(5'd1);
    service(1000, 40, -1, 0, 1'b0, 4'h0);
    checks++; if (bus.error !== 1'b1 || bus.eng_en !== 4'h0 || run_len_log[0] !== 20) begin failures++; $display("FAIL timeout_trip got err=%b en=%h len=%0d exp 1/0/20", bus.error, bus.eng_en, run_len_log[0]); end
    kick(5'd1);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.error !== 1'b1 || bus.busy !== 1'b1 || bus.eng_clr_n !== 4'hF) begin failures++; $display("FAIL timeout_start_ignored got err=%b busy=%b clr=%h exp 1/1/f", bus.error, bus.busy, bus.eng_clr_n); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++; if (bus.error !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL timeout_abort got err=%b busy=%b exp 0/0", bus.error, bus.busy); end
  endtask
`endif

  task automatic test_async_reset;
    write_cfg(4'd0, 2'd3);
    kick(5'd1);
    repeat (4) @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.eng_en !== 4'b1000) begin failures++; $display("FAIL async_pre_run got=%b exp=1000", bus.eng_en); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.eng_en !== 4'h0 || bus.busy !== 1'b0 || bus.eng_clr_n !== 4'hF || bus.layer_idx !== 4'd0) begin failures++; $display("FAIL async_reset got en=%h busy=%b clr=%h idx=%0d exp 0/0/f/0", bus.eng_en, bus.busy, bus.eng_clr_n, bus.layer_idx); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.num_layers = '0;
    bus.cfg_we     = 1'b0;
    bus.cfg_idx    = '0;
    bus.cfg_type   = '0;
    bus.eng_done   = 4'h0;
    test_reset();
    test_single_layer();
    test_four_layers();
    test_zero_layers();
    test_abort();
    test_busy_write_and_noise();
    test_start_rules();
`ifdef LAYER_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
